rv_trap_ctrl: RTL and testbench

Machine-mode trap controller. It owns mstatus, mie, mip, mepc and mcause, and supplies their values to the CSR read mux. It consumes the CSR unit's computed write value and selector to update those registers. It also detects pending interrupts, runs the interrupt request/acknowledge handshake with the execute stage, and records synchronous exceptions and mret.

---
 rtl/rv_trap_ctrl.sv | 271 +++++++++++++++++++++++++++
 tb/tb_rv_trap_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_trap_ctrl.sv
// rv_trap_ctrl: machine-mode trap controller.
// Holds mstatus/mie/mip/mepc/mcause and supplies their read values.
// Synchronises the external interrupt line and raises an interrupt request
// toward the execute stage through a REQ/HOLD handshake.
// Records synchronous exceptions and mret.

module rv_trap_ctrl #(
    parameter logic [31:0] TRAP_VECTOR     = 32'h00000008,
    parameter int          IRQ_SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        x_stall_i,
    input  logic        x_kill_i,
    input  logic        d_is_csr_i,
    input  logic [11:0] d_csr_sel_i,
    input  logic [31:0] x_csr_write_value_i,
    input  logic        x_exception_i,
    input  logic [3:0]  x_exception_cause_i,
    input  logic [31:0] x_pc_i,
    input  logic        d_is_mret_i,
    input  logic        irq_i,
    input  logic        timer_tick_i,
    input  logic        irq_ack_i,
    output logic        x_irq_req_o,
    output logic [31:0] x_trap_vector_o,
    output logic [31:0] csr_mstatus_o,
    output logic [31:0] csr_mip_o,
    output logic [31:0] csr_mie_o,
    output logic [31:0] csr_mepc_o,
    output logic [31:0] csr_mcause_o
);

    // Machine CSR addresses
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Interrupt cause selection: external beats timer beats software.
    function automatic logic [3:0] select_cause(
        input logic meip, input logic meie,
        input logic mtip, input logic mtie,
        input logic msip, input logic msie
    );
        logic [3:0] cause;
        if (meip && meie) begin
            cause = 4'd11;
        end else if (mtip && mtie) begin
            cause = 4'd7;
        end else if (msip && msie) begin
            cause = 4'd3;
        end else begin
            cause = 4'd0;
        end
        return cause;
    endfunction

    // Architectural state
    logic        mie_r;
    logic        mpie_r;
    logic        msie_r;
    logic        mtie_r;
    logic        meie_r;
    logic        mtip_r;
    logic [29:0] mepc_r;
    logic        mcause_int_r;
    logic [3:0]  mcause_code_r;
    logic [IRQ_SYNC_STAGES-1:0] irq_sync_r;

    // Handshake state
    state_t      state_r;
    state_t      state_next_s;
    logic        req_r;
    logic [3:0]  cause_r;

    // Qualified events
    logic        commit_s;
    logic        exc_commit_s;
    logic        mret_commit_s;
    logic        ack_take_s;
    logic        csr_apply_s;
    logic        mtip_wr_s;
    logic        meip_s;
    logic        msip_s;
    logic        pending_s;
    logic [3:0]  sel_cause_s;
    logic        unused_s;

    assign commit_s      = !x_stall_i && !x_kill_i;
    assign exc_commit_s  = commit_s && x_exception_i;
    assign mret_commit_s = commit_s && d_is_mret_i && !x_exception_i;
    // The pipeline takes the interrupt only when no exception commits alongside it.
    assign ack_take_s    = (state_r == ST_REQ) && irq_ack_i && !exc_commit_s;
    // A CSR write is dropped when a trap or mret claims the same cycle.
    assign csr_apply_s   = commit_s && d_is_csr_i && !exc_commit_s
                           && !ack_take_s && !mret_commit_s;
    assign mtip_wr_s     = csr_apply_s && (d_csr_sel_i == CSR_MIP);

    assign meip_s        = irq_sync_r[IRQ_SYNC_STAGES-1];
    // Software interrupt is never raised by hardware.
    assign msip_s        = 1'b0;
    assign pending_s     = mie_r && ((meip_s && meie_r) || (mtip_r && mtie_r)
                                     || (msip_s && msie_r));
    assign sel_cause_s   = select_cause(meip_s, meie_r, mtip_r, mtie_r, msip_s, msie_r);

    assign unused_s      = ^x_pc_i[1:0];

    // Synchronise the asynchronous external interrupt level.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            irq_sync_r <= '0;
        end else begin
            irq_sync_r <= {irq_sync_r[IRQ_SYNC_STAGES-2:0], irq_i};
        end
    end

    // Handshake next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pending_s && !exc_commit_s && !mret_commit_s) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack_take_s) begin
                    state_next_s = ST_HOLD;
                end else if (exc_commit_s || !pending_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_HOLD: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Handshake state register, registered request and cause latched on REQ entry.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= ST_IDLE;
            req_r   <= 1'b0;
            cause_r <= 4'd0;
        end else begin
            state_r <= state_next_s;
            req_r   <= (state_next_s == ST_REQ);
            if ((state_r == ST_IDLE) && (state_next_s == ST_REQ)) begin
                cause_r <= sel_cause_s;
            end
        end
    end

    // Timer pending bit: a tick sets it and wins over a same-cycle clearing write.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mtip_r <= 1'b0;
        end else begin
            mtip_r <= timer_tick_i | (mtip_wr_s ? x_csr_write_value_i[7] : mtip_r);
        end
    end

    // Trap capture, mret and CSR writes, in decreasing priority.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mie_r         <= 1'b0;
            mpie_r        <= 1'b0;
            msie_r        <= 1'b0;
            mtie_r        <= 1'b0;
            meie_r        <= 1'b0;
            mepc_r        <= 30'd0;
            mcause_int_r  <= 1'b0;
            mcause_code_r <= 4'd0;
        end else if (exc_commit_s) begin
            mepc_r        <= x_pc_i[31:2];
            mcause_int_r  <= 1'b0;
            mcause_code_r <= x_exception_cause_i;
            mpie_r        <= mie_r;
            mie_r         <= 1'b0;
        end else if (ack_take_s) begin
            mepc_r        <= x_pc_i[31:2];
            mcause_int_r  <= 1'b1;
            mcause_code_r <= cause_r;
            mpie_r        <= mie_r;
            mie_r         <= 1'b0;
        end else if (mret_commit_s) begin
            mie_r         <= mpie_r;
            mpie_r        <= 1'b1;
        end else if (csr_apply_s) begin
            case (d_csr_sel_i)
                CSR_MSTATUS: begin
                    mie_r  <= x_csr_write_value_i[3];
                    mpie_r <= x_csr_write_value_i[7];
                end
                CSR_MIE: begin
                    msie_r <= x_csr_write_value_i[3];
                    mtie_r <= x_csr_write_value_i[7];
                    meie_r <= x_csr_write_value_i[11];
                end
                CSR_MEPC: begin
                    mepc_r <= x_csr_write_value_i[31:2];
                end
                CSR_MCAUSE: begin
                    mcause_int_r  <= x_csr_write_value_i[31];
                    mcause_code_r <= x_csr_write_value_i[3:0];
                end
                default: begin
                    // mip is handled by the timer-pending block; others ignored
                end
            endcase
        end
    end

    // All outputs are direct register images.
    assign x_irq_req_o     = req_r;
    assign x_trap_vector_o = TRAP_VECTOR;
    assign csr_mstatus_o   = {24'd0, mpie_r, 3'd0, mie_r, 3'd0};
    assign csr_mie_o       = {20'd0, meie_r, 3'd0, mtie_r, 3'd0, msie_r, 3'd0};
    assign csr_mip_o       = {20'd0, meip_s, 3'd0, mtip_r, 3'd0, msip_s, 3'd0};
    assign csr_mepc_o      = {mepc_r, 2'b00};
    assign csr_mcause_o    = {mcause_int_r, 27'd0, mcause_code_r};

    rv_trap_ctrl_chk u_chk (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .req     (req_r),
        .ack     (irq_ack_i),
        .in_hold (state_r == ST_HOLD),
        .mstatus (csr_mstatus_o)
    );

endmodule

// Handshake property checker.
module rv_trap_ctrl_chk (
    input logic        clk,
    input logic        rst_n,
    input logic        req,
    input logic        ack,
    input logic        in_hold,
    input logic [31:0] mstatus
);

    // An acknowledged request never stays up the following cycle.
    a_ack_drops: assert property (@(posedge clk) disable iff (!rst_n)
        (req && ack) |=> !req);

    // HOLD lasts exactly one cycle and never requests.
    a_hold_one: assert property (@(posedge clk) disable iff (!rst_n)
        in_hold |=> !in_hold && !req);

    // Only MIE and MPIE are ever visible in mstatus.
    a_mstatus_bits: assert property (@(posedge clk) disable iff (!rst_n)
        (mstatus & 32'hFFFFFF77) == 32'd0);

endmodule

// File: tb/tb_rv_trap_ctrl.sv
// Directed self-checking bench for rv_trap_ctrl.
module tb_rv_trap_ctrl;

    localparam logic [11:0] SEL_MSTATUS = 12'h300;
    localparam logic [11:0] SEL_MIE     = 12'h304;
    localparam logic [11:0] SEL_MEPC    = 12'h341;
    localparam logic [11:0] SEL_MCAUSE  = 12'h342;
    localparam logic [11:0] SEL_MIP     = 12'h344;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        x_stall = 1'b0;
    logic        x_kill = 1'b0;
    logic        d_is_csr = 1'b0;
    logic [11:0] d_csr_sel = 12'd0;
    logic [31:0] wval = 32'd0;
    logic        x_exc = 1'b0;
    logic [3:0]  x_exc_cause = 4'd0;
    logic [31:0] x_pc = 32'd0;
    logic        d_is_mret = 1'b0;
    logic        irq = 1'b0;
    logic        timer_tick = 1'b0;
    logic        irq_ack = 1'b0;
    logic        req;
    logic [31:0] vec, mstatus, mip, mie, mepc, mcause;

    int n_checks = 0;
    int n_fail = 0;

    rv_trap_ctrl dut (
        .clk_i               (clk),
        .rst_n_i             (rst_n),
        .x_stall_i           (x_stall),
        .x_kill_i            (x_kill),
        .d_is_csr_i          (d_is_csr),
        .d_csr_sel_i         (d_csr_sel),
        .x_csr_write_value_i (wval),
        .x_exception_i       (x_exc),
        .x_exception_cause_i (x_exc_cause),
        .x_pc_i              (x_pc),
        .d_is_mret_i         (d_is_mret),
        .irq_i               (irq),
        .timer_tick_i        (timer_tick),
        .irq_ack_i           (irq_ack),
        .x_irq_req_o         (req),
        .x_trap_vector_o     (vec),
        .csr_mstatus_o       (mstatus),
        .csr_mip_o           (mip),
        .csr_mie_o           (mie),
        .csr_mepc_o          (mepc),
        .csr_mcause_o        (mcause)
    );

    always #5 clk = ~clk;

    // Advance n clock edges, leaving time 1 unit after the last edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One committed CSR write cycle.
    task automatic csr_write(input logic [11:0] sel, input logic [31:0] val);
        d_is_csr = 1'b1; d_csr_sel = sel; wval = val;
        tick(1);
        d_is_csr = 1'b0; wval = 32'd0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        n_checks++; if (mstatus !== 32'd0) begin n_fail++; $display("FAIL rst_mstatus: got %h expected %h", mstatus, 32'd0); end
        n_checks++; if (mie !== 32'd0) begin n_fail++; $display("FAIL rst_mie: got %h expected %h", mie, 32'd0); end
        n_checks++; if (mip !== 32'd0) begin n_fail++; $display("FAIL rst_mip: got %h expected %h", mip, 32'd0); end
        n_checks++; if (mepc !== 32'd0) begin n_fail++; $display("FAIL rst_mepc: got %h expected %h", mepc, 32'd0); end
        n_checks++; if (mcause !== 32'd0) begin n_fail++; $display("FAIL rst_mcause: got %h expected %h", mcause, 32'd0); end
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected %b", req, 1'b0); end
        n_checks++; if (vec !== 32'h8) begin n_fail++; $display("FAIL trap_vector: got %h expected %h", vec, 32'h8); end
        // asynchronous assertion mid-cycle
        csr_write(SEL_MIE, 32'hFFFFFFFF);
        csr_write(SEL_MSTATUS, 32'h00000088);
        n_checks++; if (mie !== 32'h888) begin n_fail++; $display("FAIL pre_async_mie: got %h expected %h", mie, 32'h888); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (mie !== 32'd0) begin n_fail++; $display("FAIL async_mie: got %h expected %h", mie, 32'd0); end
        n_checks++; if (mstatus !== 32'd0) begin n_fail++; $display("FAIL async_mstatus: got %h expected %h", mstatus, 32'd0); end
        #1 rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_csr_mask;
        csr_write(SEL_MIE, 32'hFFFFFFFF);
        n_checks++; if (mie !== 32'h888) begin n_fail++; $display("FAIL mask_mie: got %h expected %h", mie, 32'h888); end
        csr_write(SEL_MSTATUS, 32'hFFFFFFFF);
        n_checks++; if (mstatus !== 32'h88) begin n_fail++; $display("FAIL mask_mstatus: got %h expected %h", mstatus, 32'h88); end
        x_stall = 1'b1;
        csr_write(SEL_MIE, 32'd0);
        csr_write(SEL_MSTATUS, 32'd0);
        x_stall = 1'b0;
        n_checks++; if (mie !== 32'h888) begin n_fail++; $display("FAIL stall_mie: got %h expected %h", mie, 32'h888); end
        n_checks++; if (mstatus !== 32'h88) begin n_fail++; $display("FAIL stall_mstatus: got %h expected %h", mstatus, 32'h88); end
        csr_write(SEL_MEPC, 32'hFFFFFFFF);
        n_checks++; if (mepc !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL mask_mepc: got %h expected %h", mepc, 32'hFFFFFFFC); end
        csr_write(SEL_MCAUSE, 32'hFFFFFFFF);
        n_checks++; if (mcause !== 32'h8000000F) begin n_fail++; $display("FAIL mask_mcause: got %h expected %h", mcause, 32'h8000000F); end
        csr_write(12'h305, 32'h00000000);
        n_checks++; if (mie !== 32'h888 || mstatus !== 32'h88) begin n_fail++; $display("FAIL unknown_sel: got mie %h mstatus %h expected %h %h", mie, mstatus, 32'h888, 32'h88); end
        csr_write(SEL_MSTATUS, 32'd0);
        csr_write(SEL_MIP, 32'hFFFFFFFF);
        n_checks++; if (mip !== 32'h80) begin n_fail++; $display("FAIL mask_mip: got %h expected %h", mip, 32'h80); end
        csr_write(SEL_MIP, 32'd0);
        n_checks++; if (mip !== 32'd0) begin n_fail++; $display("FAIL mip_clear: got %h expected %h", mip, 32'd0); end
        csr_write(SEL_MIE, 32'd0);
    endtask

    task automatic test_ext_irq;
        csr_write(SEL_MIE, 32'h800);
        csr_write(SEL_MSTATUS, 32'h8);
        irq = 1'b1;
        tick(2);
        n_checks++; if (mip !== 32'h800 || req !== 1'b0) begin n_fail++; $display("FAIL ext_sync: got mip %h req %b expected %h %b", mip, req, 32'h800, 1'b0); end
        tick(1);
        n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL ext_req_rise: got %b expected %b", req, 1'b1); end
        tick(2);
        n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL ext_req_hold: got %b expected %b", req, 1'b1); end
        irq_ack = 1'b1; x_pc = 32'h104;
        tick(1);
        irq_ack = 1'b0;
        n_checks++; if (mepc !== 32'h104) begin n_fail++; $display("FAIL ext_mepc: got %h expected %h", mepc, 32'h104); end
        n_checks++; if (mcause !== 32'h8000000B) begin n_fail++; $display("FAIL ext_mcause: got %h expected %h", mcause, 32'h8000000B); end
        n_checks++; if (mstatus !== 32'h80) begin n_fail++; $display("FAIL ext_mstatus: got %h expected %h", mstatus, 32'h80); end
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL ext_req_ack: got %b expected %b", req, 1'b0); end
        tick(1);
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL ext_req_hold_low: got %b expected %b", req, 1'b0); end
        irq = 1'b0;
        tick(3);
        d_is_mret = 1'b1;
        tick(1);
        d_is_mret = 1'b0;
        n_checks++; if (mstatus !== 32'h88) begin n_fail++; $display("FAIL mret_mstatus: got %h expected %h", mstatus, 32'h88); end
        tick(1);
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL mret_no_req: got %b expected %b", req, 1'b0); end
        csr_write(SEL_MSTATUS, 32'd0);
        csr_write(SEL_MIE, 32'd0);
    endtask

    task automatic test_exception;
        x_exc = 1'b1; x_exc_cause = 4'd2; x_pc = 32'h20E;
        tick(1);
        n_checks++; if (mepc !== 32'h20C) begin n_fail++; $display("FAIL exc_mepc: got %h expected %h", mepc, 32'h20C); end
        n_checks++; if (mcause !== 32'h2) begin n_fail++; $display("FAIL exc_mcause: got %h expected %h", mcause, 32'h2); end
        x_kill = 1'b1; x_exc_cause = 4'd5; x_pc = 32'h300;
        tick(1);
        x_kill = 1'b0;
        n_checks++; if (mepc !== 32'h20C || mcause !== 32'h2) begin n_fail++; $display("FAIL exc_kill: got mepc %h mcause %h expected %h %h", mepc, mcause, 32'h20C, 32'h2); end
        // exception wins over a CSR write in the same cycle
        x_exc_cause = 4'd6; x_pc = 32'h310;
        csr_write(SEL_MIE, 32'hFFFFFFFF);
        x_exc = 1'b0;
        n_checks++; if (mie !== 32'd0 || mcause !== 32'h6 || mepc !== 32'h310) begin n_fail++; $display("FAIL exc_over_csr: got mie %h mcause %h mepc %h expected %h %h %h", mie, mcause, mepc, 32'd0, 32'h6, 32'h310); end
    endtask

    task automatic test_collision;
        csr_write(SEL_MIE, 32'h800);
        csr_write(SEL_MSTATUS, 32'h8);
        irq = 1'b1;
        tick(3);
        n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL col_req: got %b expected %b", req, 1'b1); end
        x_exc = 1'b1; x_exc_cause = 4'd4; x_pc = 32'h400; irq_ack = 1'b1;
        tick(1);
        x_exc = 1'b0; irq_ack = 1'b0;
        n_checks++; if (mcause !== 32'h4) begin n_fail++; $display("FAIL col_mcause: got %h expected %h", mcause, 32'h4); end
        n_checks++; if (mepc !== 32'h400) begin n_fail++; $display("FAIL col_mepc: got %h expected %h", mepc, 32'h400); end
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL col_req_drop: got %b expected %b", req, 1'b0); end
        irq = 1'b0;
        tick(3);
        // withdrawal: MIE cleared before the ack arrives
        csr_write(SEL_MSTATUS, 32'h8);
        irq = 1'b1;
        tick(3);
        n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL wd_req: got %b expected %b", req, 1'b1); end
        csr_write(SEL_MSTATUS, 32'd0);
        tick(1);
        n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL wd_req_drop: got %b expected %b", req, 1'b0); end
        n_checks++; if (mepc !== 32'h400) begin n_fail++; $display("FAIL wd_mepc: got %h expected %h", mepc, 32'h400); end
        irq = 1'b0;
        tick(3);
        csr_write(SEL_MIE, 32'd0);
    endtask

    task automatic test_timer;
        csr_write(SEL_MIE, 32'h80);
        csr_write(SEL_MSTATUS, 32'h8);
        timer_tick = 1'b1;
        tick(1);
        timer_tick = 1'b0;
        n_checks++; if (mip !== 32'h80) begin n_fail++; $display("FAIL tmr_mip: got %h expected %h", mip, 32'h80); end
        tick(1);
        n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL tmr_req: got %b expected %b", req, 1'b1); end
        irq_ack = 1'b1; x_pc = 32'h500;
        tick(1);
        irq_ack = 1'b0;
        n_checks++; if (mcause !== 32'h80000007) begin n_fail++; $display("FAIL tmr_mcause: got %h expected %h", mcause, 32'h80000007); end
        n_checks++; if (mepc !== 32'h500) begin n_fail++; $display("FAIL tmr_mepc: got %h expected %h", mepc, 32'h500); end
        // external and timer pending together: external wins
        csr_write(SEL_MIE, 32'h880);
        irq = 1'b1;
        tick(2);
        csr_write(SEL_MSTATUS, 32'h8);
        tick(1);
        n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL prio_req: got %b expected %b", req, 1'b1); end
        irq_ack = 1'b1; x_pc = 32'h600;
        tick(1);
        irq_ack = 1'b0; irq = 1'b0;
        n_checks++; if (mcause !== 32'h8000000B) begin n_fail++; $display("FAIL prio_mcause: got %h expected %h", mcause, 32'h8000000B); end
        // tick and clearing write in the same cycle: set wins
        timer_tick = 1'b1;
        csr_write(SEL_MIP, 32'd0);
        timer_tick = 1'b0;
        n_checks++; if (mip[7] !== 1'b1) begin n_fail++; $display("FAIL tmr_set_wins: got %b expected %b", mip[7], 1'b1); end
        csr_write(SEL_MIP, 32'd0);
        n_checks++; if (mip[7] !== 1'b0) begin n_fail++; $display("FAIL tmr_clear: got %b expected %b", mip[7], 1'b0); end
    endtask

    initial begin
        test_reset();
        test_csr_mask();
        test_ext_irq();
        test_exception();
        test_collision();
        test_timer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
